// File: rtl/tree_pkg.sv
// Shared types and constants for the tree fan-in collector: FSM encoding,
// child-index width and the round-robin index helper.
package tree_pkg;

   localparam int MAX_CHILD = 8;
   localparam int SRC_W     = $clog2(MAX_CHILD);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SIGNAL = 2'd2
   } fsm_state_t;

   typedef logic [SRC_W-1:0] src_idx_t;

   // (base + k) mod n for base < n and 1 <= k <= n, without a divider.
   function automatic int rr_index(input int base, input int k, input int n);
      int sum;
      sum = base + k;
      return (sum >= n) ? sum - n : sum;
   endfunction

endpackage

// File: rtl/tree_fanin_collector_if.sv
// Child fan-in and parent stream signals of the collector, bundled with
// modports for the collector (slave) and its environment (master).
interface tree_fanin_collector_if #(
   parameter int N_CHILD = 5,
   parameter int DATA_W  = 16
) ();
   import tree_pkg::*;

   logic [N_CHILD-1:0]        c_valid;
   logic [N_CHILD*DATA_W-1:0] c_data;
   logic [N_CHILD-1:0]        c_last;
   logic [N_CHILD-1:0]        c_ready;
   logic                      p_valid;
   logic [DATA_W-1:0]         p_data;
   logic [SRC_W-1:0]          p_src;
   logic                      p_ready;
   logic                      all_done;

   modport master (
      output c_valid, c_data, c_last, p_ready,
      input  c_ready, p_valid, p_data, p_src, all_done
   );

   modport slave (
      input  c_valid, c_data, c_last, p_ready,
      output c_ready, p_valid, p_data, p_src, all_done
   );

endinterface

// File: rtl/tree_fanin_collector_arbiter.sv
// Round-robin arbiter: searches requests starting one past ptr and returns
// a one-hot grant plus the binary index of the winner.
module rr_arbiter
   import tree_pkg::*;
#(
   parameter int N_CHILD = 5
) (
   input  logic [N_CHILD-1:0] req,
   input  src_idx_t           ptr,
   output logic [N_CHILD-1:0] grant,
   output src_idx_t           index,
   output logic               any
);

   localparam int IDX_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      cand  = '0;
      // k == N_CHILD wraps back to ptr itself, so the last winner is tried last.
      for (int k = 1; k <= N_CHILD; k++) begin
         cand = IDX_W'(rr_index(int'(ptr), k, N_CHILD));
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            index       = src_idx_t'(cand);
         end
      end
   end

endmodule

// File: rtl/tree_fanin_collector.sv
// Collects beats from N_CHILD children through a round-robin arbiter into a
// 2-entry FIFO and flags when every child has delivered its last beat.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | collecting; grants issued while the FIFO has room
// ST_DRAIN  | every child finished, waiting for the FIFO to empty
// ST_SIGNAL | one-cycle all_done pulse, done_mask clears
module tree_fanin_collector
   import tree_pkg::*;
#(
   parameter int N_CHILD = 5,
   parameter int DATA_W  = 16
) (
   input logic                    clk,
   input logic                    rst,
   tree_fanin_collector_if.slave  bus
);

   fsm_state_t         state, state_next;
   logic [N_CHILD-1:0] done_mask;
   logic [N_CHILD-1:0] req, grant;
   src_idx_t           ptr, grant_idx;
   logic               grant_any, grant_en, clr_mask, all_done_i;

   logic [DATA_W-1:0]  fifo_data [2];
   src_idx_t           fifo_src  [2];
   logic               rd_sel, wr_sel;
   logic [1:0]         count, count_next;
   logic               push, pop, room;
   logic [DATA_W-1:0]  push_data;
   logic               push_last;

   assign pop  = (count != 2'd0) && bus.p_ready;
   // A same-cycle pop frees the slot the new beat will land in.
   assign room = (count != 2'd2) || pop;
   assign req  = bus.c_valid & ~done_mask;

   rr_arbiter #(.N_CHILD(N_CHILD)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .index (grant_idx),
      .any   (grant_any)
   );

   assign bus.c_ready = grant & {N_CHILD{grant_en}};
   assign push        = grant_en & grant_any;
   assign push_last   = |(grant & bus.c_last);

   always_comb begin
      push_data = '0;
      for (int i = 0; i < N_CHILD; i++) begin
         if (grant[i]) push_data = bus.c_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      case ({push, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         rd_sel    <= 1'b0;
         wr_sel    <= 1'b0;
         ptr       <= src_idx_t'(N_CHILD - 1);
         done_mask <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_src[i]  <= '0;
         end
      end else begin
         count <= count_next;
         if (push) begin
            fifo_data[wr_sel] <= push_data;
            fifo_src[wr_sel]  <= grant_idx;
            wr_sel            <= ~wr_sel;
            ptr               <= grant_idx;
         end
         if (pop) rd_sel <= ~rd_sel;
         if (clr_mask) begin
            done_mask <= '0;
         end else if (push && push_last) begin
            done_mask <= done_mask | grant;
         end
      end
   end

   assign bus.p_valid = (count != 2'd0);
   assign bus.p_data  = fifo_data[rd_sel];
   assign bus.p_src   = fifo_src[rd_sel];

   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_next;
   end

   // Emptiness is judged on the post-edge occupancy so the pulse follows
   // the cycle in which the final beat leaves.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (&done_mask) state_next = (count_next == 2'd0) ? ST_SIGNAL : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (count_next == 2'd0) state_next = ST_SIGNAL;
         end
         ST_SIGNAL: state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
   end

   always_comb begin
      grant_en   = (state == ST_RUN) && !rst && room;
      clr_mask   = (state == ST_SIGNAL);
      all_done_i = (state == ST_SIGNAL);
   end

   assign bus.all_done = all_done_i;

endmodule

// File: tb/tb_tree_fanin_collector.sv
// Self-checking bench for tree_fanin_collector: directed tables, corner
// sequences and a randomized run against a queue-based reference model.
module tb_tree_fanin_collector;
   import tree_pkg::*;

   localparam int N = 5;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tree_fanin_collector_if #(.N_CHILD(N), .DATA_W(W)) bus ();

   tree_fanin_collector #(.N_CHILD(N), .DATA_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] cd [N];

   typedef struct {
      logic [N-1:0] v;
      logic [W-1:0] d2;
      logic         pr;
      logic [N-1:0] rdy;
      logic         pv;
      logic [W-1:0] pd;
      logic [2:0]   src;
   } vec_t;
   vec_t tbl [8];

   // reference model state
   logic [W-1:0] mq_d [$];
   int           mq_s [$];
   int           m_ptr, m_phase, exp_g, pop_i, pulses;
   logic [N-1:0] m_done, rv, rl, er;
   logic         rr, rpr, all_before;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic pr);
      rst         = r;
      bus.c_valid = v;
      bus.c_last  = l;
      bus.p_ready = pr;
      for (int i = 0; i < N; i++) bus.c_data[i*W +: W] = cd[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) cd[i] = 16'hC000 + W'(i);
      apply(1'b1, '0, '0, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) cd[i] = 16'hC000 + W'(i);

      // reset values, c_ready held low while rst is high
      apply(1'b1, '1, '0, 1'b1);
      @(negedge clk);
      chk("rst_c_ready", bus.c_ready, 0);
      chk("rst_p_valid", bus.p_valid, 0);
      chk("rst_p_data", bus.p_data, 0);
      chk("rst_p_src", bus.p_src, 0);
      chk("rst_all_done", bus.all_done, 0);
      tick();
      apply(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("post_rst_p_valid", bus.p_valid, 0);
      chk("post_rst_c_ready", bus.c_ready, 0);
      tick();

      // backpressure table: child 2 fills the FIFO while the parent stalls
      tbl[0] = '{v:5'b00100, d2:16'hA5A5, pr:1'b0, rdy:5'b00100, pv:1'b0, pd:16'h0,    src:3'd0};
      tbl[1] = '{v:5'b00100, d2:16'h5A5A, pr:1'b0, rdy:5'b00100, pv:1'b1, pd:16'hA5A5, src:3'd2};
      tbl[2] = '{v:5'b00100, d2:16'h1111, pr:1'b0, rdy:5'b00000, pv:1'b1, pd:16'hA5A5, src:3'd2};
      tbl[3] = '{v:5'b00100, d2:16'h1111, pr:1'b0, rdy:5'b00000, pv:1'b1, pd:16'hA5A5, src:3'd2};
      tbl[4] = '{v:5'b00100, d2:16'h1111, pr:1'b0, rdy:5'b00000, pv:1'b1, pd:16'hA5A5, src:3'd2};
      tbl[5] = '{v:5'b00000, d2:16'h0,    pr:1'b1, rdy:5'b00000, pv:1'b1, pd:16'hA5A5, src:3'd2};
      tbl[6] = '{v:5'b00000, d2:16'h0,    pr:1'b1, rdy:5'b00000, pv:1'b1, pd:16'h5A5A, src:3'd2};
      tbl[7] = '{v:5'b00000, d2:16'h0,    pr:1'b1, rdy:5'b00000, pv:1'b0, pd:16'h0,    src:3'd0};
      do_reset();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) cd[i] = '0;
         cd[2] = tbl[r].d2;
         apply(1'b0, tbl[r].v, '0, tbl[r].pr);
         @(negedge clk);
         chk($sformatf("tbl%0d_c_ready", r), bus.c_ready, tbl[r].rdy);
         chk($sformatf("tbl%0d_p_valid", r), bus.p_valid, tbl[r].pv);
         if (tbl[r].pv) begin
            chk($sformatf("tbl%0d_p_data", r), bus.p_data, tbl[r].pd);
            chk($sformatf("tbl%0d_p_src", r), bus.p_src, tbl[r].src);
         end
         tick();
      end

      // all children valid, parent always ready: strict rotation
      do_reset();
      for (int k = 0; k < 12; k++) begin
         apply(1'b0, '1, '0, 1'b1);
         @(negedge clk);
         er = '0;
         er[k % N] = 1'b1;
         chk($sformatf("rr%0d_c_ready", k), bus.c_ready, er);
         chk($sformatf("rr%0d_p_valid", k), bus.p_valid, (k > 0));
         if (k > 0) begin
            chk($sformatf("rr%0d_p_src", k), bus.p_src, (k - 1) % N);
            chk($sformatf("rr%0d_p_data", k), bus.p_data, 16'hC000 + ((k - 1) % N));
         end
         tick();
      end

      // one last beat per child: a single all_done pulse after the drain
      do_reset();
      pulses = 0;
      for (int k = 0; k < 9; k++) begin
         apply(1'b0, (k < 7) ? '1 : '0, '1, 1'b1);
         @(negedge clk);
         er = '0;
         if (k < N) er[k] = 1'b1;
         chk($sformatf("last%0d_c_ready", k), bus.c_ready, er);
         chk($sformatf("last%0d_all_done", k), bus.all_done, (k == 6));
         if (bus.all_done) pulses++;
         tick();
      end
      chk("last_pulse_count", pulses, 1);

      // child 3 finishes early and stays valid: excluded until the pulse
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (k == 0) apply(1'b0, 5'b01000, 5'b01000, 1'b1);
         else        apply(1'b0, 5'b11111, 5'b10111, 1'b1);
         @(negedge clk);
         case (k)
            0:       er = 5'b01000;
            1:       er = 5'b10000;
            2:       er = 5'b00001;
            3:       er = 5'b00010;
            4:       er = 5'b00100;
            7:       er = 5'b01000;
            default: er = 5'b00000;
         endcase
         chk($sformatf("c3_%0d_c_ready", k), bus.c_ready, er);
         chk($sformatf("c3_%0d_all_done", k), bus.all_done, (k == 6));
         tick();
      end

      // reset with two beats buffered
      do_reset();
      apply(1'b0, 5'b00010, 5'b00000, 1'b0);
      @(negedge clk);
      chk("mid_beat0_c_ready", bus.c_ready, 5'b00010);
      tick();
      apply(1'b0, 5'b00010, 5'b00010, 1'b0);
      @(negedge clk);
      chk("mid_beat1_c_ready", bus.c_ready, 5'b00010);
      tick();
      apply(1'b1, '1, '0, 1'b0);
      @(negedge clk);
      chk("mid_rst_c_ready", bus.c_ready, 0);
      chk("mid_rst_pre_p_valid", bus.p_valid, 1);
      tick();
      apply(1'b0, '1, '0, 1'b0);
      @(negedge clk);
      chk("mid_after_p_valid", bus.p_valid, 0);
      chk("mid_after_grant0", bus.c_ready, 5'b00001);
      tick();
      apply(1'b0, 5'b00010, '0, 1'b1);
      @(negedge clk);
      chk("mid_mask_cleared", bus.c_ready, 5'b00010);
      chk("mid_src0", bus.p_src, 0);
      tick();
      apply(1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk("mid_src1", bus.p_src, 1);
      tick();

      // randomized run against the reference model
      do_reset();
      mq_d.delete();
      mq_s.delete();
      m_ptr = N - 1;
      m_done = '0;
      m_phase = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rr  = ($urandom_range(0, 199) == 0);
         rv  = N'($urandom);
         rpr = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            rl[i] = ($urandom_range(0, 5) == 0);
            cd[i] = W'($urandom);
         end
         apply(rr, rv, rl, rpr);
         @(negedge clk);

         pop_i = (mq_d.size() > 0 && rpr) ? 1 : 0;
         exp_g = -1;
         if (!rr && m_phase == 0 && (mq_d.size() - pop_i) < 2) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (exp_g < 0 && rv[c] && !m_done[c]) exp_g = c;
            end
         end
         er = '0;
         if (exp_g >= 0) er[exp_g] = 1'b1;
         chk("rnd_c_ready", bus.c_ready, er);
         chk("rnd_p_valid", bus.p_valid, (mq_d.size() > 0));
         chk("rnd_all_done", bus.all_done, (m_phase == 2));
         if (mq_d.size() > 0) begin
            chk("rnd_p_data", bus.p_data, mq_d[0]);
            chk("rnd_p_src", bus.p_src, mq_s[0]);
         end

         if (rr) begin
            mq_d.delete();
            mq_s.delete();
            m_ptr = N - 1;
            m_done = '0;
            m_phase = 0;
         end else begin
            all_before = &m_done;
            if (pop_i != 0) begin
               void'(mq_d.pop_front());
               void'(mq_s.pop_front());
            end
            if (exp_g >= 0) begin
               mq_d.push_back(cd[exp_g]);
               mq_s.push_back(exp_g);
               m_ptr = exp_g;
               if (rl[exp_g]) m_done[exp_g] = 1'b1;
            end
            if (m_phase == 2) begin
               m_phase = 0;
               m_done = '0;
            end else if (m_phase == 0 && all_before) begin
               m_phase = (mq_d.size() == 0) ? 2 : 1;
            end else if (m_phase == 1 && mq_d.size() == 0) begin
               m_phase = 2;
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
